// File: rtl/vga_scan_out.sv
`timescale 1ns/1ps
// VGA 640x480@60 scan-out: pixel-tick divider, raster counters and a registered
// output stage that keeps hsync, vsync and colour mutually aligned and blanked.
module vga_scan_out #(
    parameter int CLK_DIV    = 4,
    parameter int RD_LATENCY = 2,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_req,
    input  logic [11:0] pix_data,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_q, frame_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             tick;
    logic             h_wrap;
    logic             v_wrap;

    assign tick    = (div_q == DIV_LAST);
    assign h_wrap  = (h_q == H_LAST);
    assign v_wrap  = (v_q == V_LAST);
    assign pix_req = (h_q < H_VIS) && (v_q < V_VIS);

    always_comb begin
        // NOTE: every _d gets a default before any branch, so no path can infer a latch.
        div_d   = div_q + DIV_W'(1);
        h_d     = h_q;
        v_d     = v_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
        frame_d = 1'b0;
        if (tick) begin
            div_d = '0;
            h_d   = h_wrap ? 10'd0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d = v_wrap ? 10'd0 : v_q + 10'd1;
            end
            // Output stage samples the position being left, so it trails the counters by one pixel.
            hsync_d = ~((h_q >= HS_FIRST) && (h_q <= HS_LAST));
            vsync_d = ~((v_q >= VS_FIRST) && (v_q <= VS_LAST));
            rgb_d   = pix_req ? pix_data : 12'h000;
            frame_d = h_wrap && v_wrap;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 12'h000;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
            frame_q <= frame_d;
        end
    end

    // Colour is captured on the tick, CLK_DIV-1 clocks after the coordinate change.
    always_ff @(posedge clk) begin
        assert (RD_LATENCY <= CLK_DIV - 1);
    end

    assign pix_x       = h_q;
    assign pix_y       = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_q;
    assign {r, g, b}   = rgb_q;

endmodule

// File: tb/tb_vga_scan_out.sv
`timescale 1ns/1ps
// Scoreboard bench: lane 0 runs the full 640x480 timing, lane 1 a tiny raster
// (8+2+3+2 x 4+1+2+1) so frame wrap, vsync and last-pixel cases fit the run.
module tb_vga_scan_out;

    localparam int NL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mode   = 0;                 // 0 constant, 1 ROM model, 2 toggle every clk
    logic [11:0] const_val = 12'hFFF;
    logic armed = 1'b0;

    logic rst_l    [NL];
    int   n_l      [NL];
    int   hs_falls [NL];
    int   vs_falls [NL];
    int   fs_seen  [NL];

    typedef struct {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        hand;
        logic [11:0] hand_rgb;
        int          h;
        int          v;
    } exp_t;

    typedef struct {
        int          lane;
        int          mode;
        int          h;
        int          v;
        logic [11:0] rgb;
    } hand_t;

    hand_t hand_tab [9] = '{
        '{0, 1,   5, 3, 12'h53A},
        '{0, 1, 640, 3, 12'h000},
        '{0, 1,   0, 3, 12'h03A},
        '{0, 0, 639, 0, 12'hFFF},
        '{0, 0, 639, 4, 12'h123},
        '{0, 0, 640, 4, 12'h000},
        '{1, 1,   7, 3, 12'h73A},
        '{1, 1,   8, 3, 12'h000},
        '{1, 1,   0, 4, 12'h000}
    };

    task automatic check(input int lane, input int n, input string name,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL L%0d n=%0d %s got %0h want %0h", lane, n, name, got, want);
        end
    endtask

    for (genvar li = 0; li < NL; li++) begin : lane
        localparam int HV = (li == 0) ? 640 : 8;
        localparam int HF = (li == 0) ? 16  : 2;
        localparam int HS = (li == 0) ? 96  : 3;
        localparam int HB = (li == 0) ? 48  : 2;
        localparam int VV = (li == 0) ? 480 : 4;
        localparam int VF = (li == 0) ? 10  : 1;
        localparam int VS = 2;
        localparam int VB = (li == 0) ? 33  : 1;
        localparam int HT = HV + HF + HS + HB;
        localparam int VT = VV + VF + VS + VB;
        // Hand-computed event times in clks after reset release.
        localparam int HS_FALL = (li == 0) ? 2628    : 44;
        localparam int HS_W    = (li == 0) ? 384     : 12;
        localparam int LINE    = (li == 0) ? 3200    : 60;
        localparam int VS_FALL = (li == 0) ? 1568004 : 304;
        localparam int VS_W    = (li == 0) ? 6400    : 120;
        localparam int FRAME   = (li == 0) ? 1680000 : 480;

        logic [11:0] pix_data;
        logic [9:0]  pix_x, pix_y;
        logic        pix_req, frame_start, hsync, vsync;
        logic [3:0]  red, grn, blu;

        vga_scan_out #(
            .CLK_DIV(4), .RD_LATENCY(2),
            .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
            .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
        ) dut (
            .clk(clk), .rst(rst_l[li]),
            .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req), .pix_data(pix_data),
            .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
            .r(red), .g(grn), .b(blu)
        );

        exp_t sb_q [$];

        always @(posedge clk) begin
            if (rst_l[li]) begin
                n_l[li] = 0;
                sb_q.delete();
            end else begin
                n_l[li] = n_l[li] + 1;
            end
        end

        // Driver: feeds pix_data and pushes the expected output of each pixel period.
        initial begin : drv
            logic [11:0] hist0, hist1, rom_out;
            exp_t e;
            int k, h, v;
            pix_data = 12'h000;
            hist0 = 12'h000;
            hist1 = 12'h000;
            forever begin
                @(posedge clk);
                #2;
                rom_out = hist1;
                hist1   = hist0;
                hist0   = {pix_x[3:0], pix_y[3:0], 4'hA};
                case (mode)
                    1:       pix_data = rom_out;
                    2:       pix_data = 12'((n_l[li] * 167) ^ 32'h5C3);
                    default: pix_data = const_val;
                endcase
                if (!rst_l[li] && (n_l[li] % 4 == 3)) begin
                    k = n_l[li] / 4;
                    h = k % HT;
                    v = (k / HT) % VT;
                    e.h = h;
                    e.v = v;
                    e.hs = !((h >= HV + HF) && (h < HV + HF + HS));
                    e.vs = !((v >= VV + VF) && (v < VV + VF + VS));
                    e.rgb = ((h < HV) && (v < VV)) ? pix_data : 12'h000;
                    e.hand = 1'b0;
                    e.hand_rgb = 12'h000;
                    foreach (hand_tab[i]) begin
                        if (hand_tab[i].lane == li && hand_tab[i].mode == mode &&
                            hand_tab[i].h == h && hand_tab[i].v == v) begin
                            e.hand = 1'b1;
                            e.hand_rgb = hand_tab[i].rgb;
                        end
                    end
                    sb_q.push_back(e);
                end
            end
        end

        // Monitor: pops one entry each time the output stage loads, checks every cycle.
        initial begin : mon
            exp_t cur;
            int n, k, hs_fall_n, vs_fall_n, fs_n;
            logic hs_last, vs_last, fs_exp;
            cur.hs = 1'b1; cur.vs = 1'b1; cur.rgb = 12'h000;
            cur.hand = 1'b0; cur.hand_rgb = 12'h000; cur.h = 0; cur.v = 0;
            hs_fall_n = -1; vs_fall_n = -1; fs_n = -1;
            hs_last = 1'b1; vs_last = 1'b1;
            wait (armed);
            forever begin
                @(negedge clk);
                n = n_l[li];
                k = n / 4;
                if (n == 0) begin
                    cur.hs = 1'b1; cur.vs = 1'b1; cur.rgb = 12'h000; cur.hand = 1'b0;
                    hs_fall_n = -1; vs_fall_n = -1; fs_n = -1;
                    hs_last = 1'b1; vs_last = 1'b1;
                end else if (n % 4 == 0) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL L%0d n=%0d scoreboard empty at output load", li, n);
                    end else begin
                        cur = sb_q.pop_front();
                        if (cur.hand)
                            check(li, n, $sformatf("hand_rgb(%0d,%0d)", cur.h, cur.v),
                                  {red, grn, blu}, cur.hand_rgb);
                    end
                end
                fs_exp = (n >= 4) && (n % 4 == 0) && (k % (HT * VT) == 0);
                check(li, n, "hsync", hsync, cur.hs);
                check(li, n, "vsync", vsync, cur.vs);
                check(li, n, "rgb", {red, grn, blu}, cur.rgb);
                check(li, n, "frame_start", frame_start, fs_exp);
                check(li, n, "pix_x", pix_x, k % HT);
                check(li, n, "pix_y", pix_y, (k / HT) % VT);
                check(li, n, "pix_req", pix_req, ((k % HT) < HV) && (((k / HT) % VT) < VV));

                if (hs_last === 1'b1 && hsync === 1'b0) begin
                    hs_falls[li]++;
                    if (hs_fall_n < 0) check(li, n, "hs_first_fall", n, HS_FALL);
                    else               check(li, n, "line_period", n - hs_fall_n, LINE);
                    hs_fall_n = n;
                end
                if (hs_last === 1'b0 && hsync === 1'b1 && hs_fall_n >= 0)
                    check(li, n, "hs_width", n - hs_fall_n, HS_W);
                hs_last = hsync;

                if (vs_last === 1'b1 && vsync === 1'b0) begin
                    vs_falls[li]++;
                    if (vs_fall_n < 0) check(li, n, "vs_first_fall", n, VS_FALL);
                    else               check(li, n, "vs_period", n - vs_fall_n, FRAME);
                    vs_fall_n = n;
                end
                if (vs_last === 1'b0 && vsync === 1'b1 && vs_fall_n >= 0)
                    check(li, n, "vs_width", n - vs_fall_n, VS_W);
                vs_last = vsync;

                if (frame_start === 1'b1) begin
                    fs_seen[li]++;
                    if (fs_n < 0) check(li, n, "fs_first", n, FRAME);
                    else          check(li, n, "fs_period", n - fs_n, FRAME);
                    fs_n = n;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NL; i++) begin
            rst_l[i] = 1'b1;
            n_l[i] = 0;
            hs_falls[i] = 0;
            vs_falls[i] = 0;
            fs_seen[i] = 0;
        end
        mode = 0;
        const_val = 12'hFFF;
        repeat (3) @(posedge clk);
        #1;
        rst_l[0] = 1'b0;
        rst_l[1] = 1'b0;
        armed = 1'b1;

        repeat (6400) @(posedge clk);       // lines 0-1: white
        #1 mode = 1;                        // lines 2-3: coordinate ROM
        repeat (6400) @(posedge clk);
        #1 begin mode = 0; const_val = 12'h123; end
        repeat (6400) @(posedge clk);       // lines 4-5: constant 123
        #1 mode = 2;
        repeat (4400) @(posedge clk);       // lane 0 now at h=300, v=7
        #1 begin rst_l[0] = 1'b1; rst_l[1] = 1'b1; end
        @(posedge clk);
        #1 begin rst_l[0] = 1'b0; rst_l[1] = 1'b0; end
        repeat (1000) @(posedge clk);
        #1 begin mode = 0; const_val = 12'hFFF; end
        repeat (1000) @(posedge clk);
        @(negedge clk);

        check(0, n_l[0], "hs_falls_seen", hs_falls[0] > 0, 1);
        check(1, n_l[1], "hs_falls_seen", hs_falls[1] > 0, 1);
        check(1, n_l[1], "vs_falls_seen", vs_falls[1] > 0, 1);
        check(1, n_l[1], "fs_seen", fs_seen[1] > 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
